// File: rtl/approx_adder_error_monitor.sv
// Exhaustive-sweep error monitor for a W-bit approximate adder: drives every operand pair,
// compares the returned sum with the exact one and reports max error, worst vector, error count
// and pass/fail against ET. Optional macro APPROX_MON_STOP_ON_FAIL_EN ends the sweep at the first vector whose error exceeds ET.
module approx_adder_error_monitor #(
    parameter int unsigned W      = 2,
    parameter int unsigned ET     = 7,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [2*W-1:0]   dut_in,
    input  logic [W:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic [W:0]       max_err,
    output logic [2*W-1:0]   worst_vec,
    output logic [2*W:0]     err_cnt,
    output logic             pass
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int unsigned SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0]     SETTLE_LAST = SETTLE_M1[3:0];
    localparam logic [2*W-1:0] VEC_LAST    = '1;

    logic [2:0]     state_q, state_d;
    logic [2*W-1:0] vec_q, vec_d;
    logic [3:0]     settle_q, settle_d;
    logic [2*W-1:0] dut_in_q, dut_in_d;
    logic [W:0]     max_err_q, max_err_d;
    logic [2*W-1:0] worst_vec_q, worst_vec_d;
    logic [2*W:0]   err_cnt_q, err_cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;

    logic [W:0]     exact_s;
    logic [W:0]     err_s;
    logic           err_over_s;
    logic           max_ok_s;

    // Absolute difference in W+2-bit signed arithmetic, truncated to W+1 bits.
    function automatic logic [W:0] abs_diff(input logic [W:0] got, input logic [W:0] ref_v);
        logic signed [W+1:0] diff;
        logic signed [W+1:0] mag;
        diff = $signed({1'b0, got}) - $signed({1'b0, ref_v});
        if (diff[W+1]) begin
            mag = -diff;
        end else begin
            mag = diff;
        end
        return mag[W:0];
    endfunction

    // Error of the current vector against the exact sum, and threshold comparisons.
    always_comb begin
        exact_s    = {1'b0, vec_q[W-1:0]} + {1'b0, vec_q[2*W-1:W]};
        err_s      = abs_diff(dut_out, exact_s);
        err_over_s = ({{(31-W){1'b0}}, err_s} > ET);
        max_ok_s   = ({{(31-W){1'b0}}, max_err_q} <= ET);
    end

    // Next-state and datapath update for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        dut_in_d    = dut_in_q;
        max_err_d   = max_err_q;
        worst_vec_d = worst_vec_q;
        err_cnt_d   = err_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    max_err_d   = '0;
                    err_cnt_d   = '0;
                    worst_vec_d = '0;
                    pass_d      = 1'b0;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                dut_in_d = vec_q;
                settle_d = 4'd0;
                if (SETTLE > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (err_s != '0) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                // Strict compare keeps the earliest vector on ties.
                if (err_s > max_err_q) begin
                    max_err_d   = err_s;
                    worst_vec_d = vec_q;
                end else begin
                    max_err_d   = max_err_q;
                end
`ifdef APPROX_MON_STOP_ON_FAIL_EN
                if ((vec_q == VEC_LAST) || err_over_s) begin
`else
                if (vec_q == VEC_LAST) begin
`endif
                    state_d = S_FIN;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = max_ok_s;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            settle_q    <= 4'd0;
            dut_in_q    <= '0;
            max_err_q   <= '0;
            worst_vec_q <= '0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            settle_q    <= settle_d;
            dut_in_q    <= dut_in_d;
            max_err_q   <= max_err_d;
            worst_vec_q <= worst_vec_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign max_err   = max_err_q;
    assign worst_vec = worst_vec_q;
    assign err_cnt   = err_cnt_q;
    assign pass      = pass_q;

    // err_over_s only steers the FSM when early stop is compiled in.
    logic unused_s;
    assign unused_s = err_over_s;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Self-checking bench: two monitors (ET=7 and ET=3) sweep a behavioural approximate adder;
// results are checked against an independent error-statistics model.
module tb_approx_adder_error_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    int         mode = 0;
    logic [47:0] rand_tbl = '0;

    logic [3:0] dut_in_a, dut_in_b, worst_vec_a, worst_vec_b;
    logic [2:0] dut_out_a, dut_out_b, max_err_a, max_err_b;
    logic [4:0] err_cnt_a, err_cnt_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;

    int tests = 0;
    int fails = 0;
`ifdef APPROX_MON_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif
    localparam int SETTLE = 1;

    always #5 clk = ~clk;

    approx_adder_error_monitor #(.W(2), .ET(7), .SETTLE(SETTLE)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .max_err(max_err_a), .worst_vec(worst_vec_a),
        .err_cnt(err_cnt_a), .pass(pass_a));

    approx_adder_error_monitor #(.W(2), .ET(3), .SETTLE(SETTLE)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .max_err(max_err_b), .worst_vec(worst_vec_b),
        .err_cnt(err_cnt_b), .pass(pass_b));

    // Behavioural approximate adder: 0 exact, 1 tied 000, 2 tied 111, 3 sum^100, 4 random table.
    function automatic logic [2:0] approx_sum(input int m, input logic [47:0] tbl, input logic [3:0] v);
        int s;
        s = int'(v[1:0]) + int'(v[3:2]);
        case (m)
            0: return 3'(s);
            1: return 3'b000;
            2: return 3'b111;
            3: return 3'(s) ^ 3'b100;
            default: return tbl[v*3 +: 3];
        endcase
    endfunction

    always_comb dut_out_a = approx_sum(mode, rand_tbl, dut_in_a);
    always_comb dut_out_b = approx_sum(mode, rand_tbl, dut_in_b);

    // Reference statistics for one sweep with threshold et.
    task automatic model(input int et, output int mx, output int wv, output int cnt,
                         output int ps, output int dcyc);
        int e;
        mx = 0; wv = 0; cnt = 0;
        dcyc = 16 * (2 + SETTLE) + 1;
        for (int k = 0; k < 16; k++) begin
            e = int'(approx_sum(mode, rand_tbl, 4'(k))) - (k % 4 + k / 4);
            if (e < 0) e = -e;
            if (e != 0) cnt++;
            if (e > mx) begin mx = e; wv = k; end
            if (STOP_EN && e > et) begin
                dcyc = (k + 1) * (2 + SETTLE) + 1;
                break;
            end
        end
        ps = (mx <= et) ? 1 : 0;
    endtask

    task automatic run_sweep(input int m, input int restart_at, input string name);
        int mx_a, wv_a, cnt_a, ps_a, dc_a, mx_b, wv_b, cnt_b, ps_b, dc_b;
        int n, cyc_a, cyc_b;
        bit got_a, got_b;
        mode = m;
        model(7, mx_a, wv_a, cnt_a, ps_a, dc_a);
        model(3, mx_b, wv_b, cnt_b, ps_b, dc_b);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; got_a = 0; got_b = 0; cyc_a = -1; cyc_b = -1;
        while (!(got_a && got_b) && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done_a && !got_a) begin
                got_a = 1; cyc_a = n;
                tests++;
                if (busy_a !== 1'b0) begin fails++; $display("FAIL %s busy_a at done: got %b want 0", name, busy_a); end
            end
            if (done_b && !got_b) begin
                got_b = 1; cyc_b = n;
            end
            start = (n == restart_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        tests++; if (cyc_a != dc_a) begin fails++; $display("FAIL %s done_cycle_a: got %0d want %0d", name, cyc_a, dc_a); end
        tests++; if (cyc_b != dc_b) begin fails++; $display("FAIL %s done_cycle_b: got %0d want %0d", name, cyc_b, dc_b); end
        tests++; if (max_err_a !== 3'(mx_a)) begin fails++; $display("FAIL %s max_err_a: got %0d want %0d", name, max_err_a, mx_a); end
        tests++; if (worst_vec_a !== 4'(wv_a)) begin fails++; $display("FAIL %s worst_vec_a: got %h want %h", name, worst_vec_a, wv_a); end
        tests++; if (err_cnt_a !== 5'(cnt_a)) begin fails++; $display("FAIL %s err_cnt_a: got %0d want %0d", name, err_cnt_a, cnt_a); end
        tests++; if (pass_a !== 1'(ps_a)) begin fails++; $display("FAIL %s pass_a: got %b want %0d", name, pass_a, ps_a); end
        tests++; if (max_err_b !== 3'(mx_b)) begin fails++; $display("FAIL %s max_err_b: got %0d want %0d", name, max_err_b, mx_b); end
        tests++; if (worst_vec_b !== 4'(wv_b)) begin fails++; $display("FAIL %s worst_vec_b: got %h want %h", name, worst_vec_b, wv_b); end
        tests++; if (err_cnt_b !== 5'(cnt_b)) begin fails++; $display("FAIL %s err_cnt_b: got %0d want %0d", name, err_cnt_b, cnt_b); end
        tests++; if (pass_b !== 1'(ps_b)) begin fails++; $display("FAIL %s pass_b: got %b want %0d", name, pass_b, ps_b); end
        @(posedge clk);
        #1;
        tests++; if (done_a !== 1'b0 || done_b !== 1'b0) begin fails++; $display("FAIL %s done_pulse_width: got %b%b want 00", name, done_a, done_b); end
    endtask

    task automatic check_outputs_zero(input string name);
        tests++;
        if ({dut_in_a, max_err_a, worst_vec_a, err_cnt_a, busy_a, done_a, pass_a} !== '0) begin
            fails++; $display("FAIL %s outputs_a: got %h/%0d/%h/%0d/%b/%b/%b want all 0", name,
                              dut_in_a, max_err_a, worst_vec_a, err_cnt_a, busy_a, done_a, pass_a);
        end
        tests++;
        if ({dut_in_b, max_err_b, worst_vec_b, err_cnt_b, busy_b, done_b, pass_b} !== '0) begin
            fails++; $display("FAIL %s outputs_b: got %h/%0d/%h/%0d/%b/%b/%b want all 0", name,
                              dut_in_b, max_err_b, worst_vec_b, err_cnt_b, busy_b, done_b, pass_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_dut();
        run_sweep(0, -1, "exact");
        run_sweep(1, -1, "tied000");
        run_sweep(2, -1, "tied111");
        run_sweep(3, -1, "xor100");
    endtask

    task automatic test_random_dut();
        for (int r = 0; r < 4; r++) begin
            rand_tbl = {$urandom(), $urandom()};
            run_sweep(4, -1, "random");
        end
    endtask

    task automatic test_start_ignored();
        run_sweep(0, 10, "restart_exact");
        rand_tbl = {$urandom(), $urandom()};
        run_sweep(2, 10, "restart_tied111");
    endtask

    task automatic test_reset_abort();
        int done_seen;
        done_seen = 0;
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("abort_in_reset");
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("abort_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (done_a || done_b || busy_a || busy_b) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin fails++; $display("FAIL abort_no_done: got %0d active cycles want 0", done_seen); end
        rand_tbl = {$urandom(), $urandom()};
        run_sweep(4, -1, "after_abort");
    endtask

    initial begin
        test_reset();
        test_fixed_dut();
        test_random_dut();
        test_start_ignored();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
